tick_period_monitor: RTL
========================

# tick_period_monitor

Receiving-end checker for the periodic single-cycle tick used to pace brush motion on the VGA path. Measures the interval in Origin_Clock cycles between successive ticks, reports each measured period, declares lock after a run of in-tolerance periods, and flags a missing-tick timeout. It sits beside the tick consumer for on-board debug and self-check; it never alters the tick.

## Interface
- EXPECTED, 500000, nominal tick period in cycles
- TOL, 16, allowed absolute deviation from EXPECTED for a period to count as a match
- LOCK_COUNT, 4, consecutive matching periods needed to assert locked (≥1)
- TIMEOUT, 1000000, cycles since last tick after which timeout fires (> EXPECTED+TOL)
- CNT_W, 24, counter/period width; must hold TIMEOUT

- Origin_Clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- pulse  in  1  tick input; rising edge (high now, low last cycle) is one tick
- period  out  CNT_W  last measured interval
- period_valid  out  1  one-cycle strobe when period updates
- locked  out  1  tick rate confirmed
- timeout  out  1  sticky missing-tick flag
- period_min  out  CNT_W  smallest period since reset/timeout (see Configuration)
- period_max  out  CNT_W  largest period since reset/timeout (see Configuration)

## Operation
- Edge detect: tick = pulse & ~pulse_d; pulse_d registered, reset 0. A pulse held high N cycles is one tick.
- States: IDLE (no reference tick), MEASURE (counting, not locked), LOCKED.
- Counter cnt: cleared to 0 on every tick, increments each cycle otherwise, saturates at TIMEOUT-1.
- IDLE + tick -> MEASURE; cnt=0; no period_valid; timeout cleared to 0.
- MEASURE/LOCKED + tick: period <= cnt+1; period_valid=1; match = |cnt+1 − EXPECTED| ≤ TOL (compare unsigned, no wrap).
  - match: match_cnt <= min(match_cnt+1, LOCK_COUNT); reaching LOCK_COUNT -> LOCKED, locked=1.
  - mismatch: match_cnt=0, locked=0, state MEASURE.
- MEASURE/LOCKED, no tick, cnt+1 == TIMEOUT: timeout=1, locked=0, match_cnt=0, -> IDLE. period holds its last value.
- Tick on the same cycle cnt+1 == TIMEOUT: tick wins; measured normally as period TIMEOUT (mismatch); no timeout.
- IDLE ignores cnt; timeout stays set until the next tick.

## Timing
- All outputs registered; updates occur on the clock edge that first samples pulse high (no extra latency).
- period_valid high exactly one cycle per accepted tick; never in IDLE.
- Reset values: period=0, period_valid=0, locked=0, timeout=0, period_min=all ones (with macro) / 0 (without), period_max=0; state IDLE; match_cnt=0; cnt=0.
- Reset mid-operation: immediate return to reset values; the first tick after release is the reference tick, not a measurement.
- Tick period of 1 (pulse toggling every cycle is impossible; high-high is one tick) — minimum measurable period 2.

## Configuration
- TICK_MON_MINMAX_EN defined: period_min/period_max update on every period_valid (min = smaller, max = larger); both reinitialised to reset values on timeout.
- Undefined: min/max logic not built; period_min and period_max tied to 0. Everything else identical.

## Test plan
Bench parameters: EXPECTED=20, TOL=1, LOCK_COUNT=4, TIMEOUT=40, CNT_W=8.
- Reset asserted, then released with pulse low -> all outputs at reset values; no period_valid for 100 cycles.
- Single-cycle ticks every 20 cycles -> no strobe on 1st tick; ticks 2–5 give period=20 with period_valid; locked rises on the 5th tick edge.
- Locked, then a 21-cycle interval -> locked stays 1; then a 22-cycle interval -> period=22, locked=0; four 20-cycle intervals re-lock.
- Locked, pulses stop -> timeout=1, locked=0 exactly 40 cycles after the last tick; next tick clears timeout without period_valid; tick at cycle 40 -> period=40, no timeout.
- Pulse held high 5 cycles at 20-cycle spacing -> counted once per rising edge, period=20; reset asserted mid-count -> outputs return to reset values within the same edge.
- With TICK_MON_MINMAX_EN, intervals 19,21,20 -> period_min=19, period_max=21; after timeout -> min=0xFF, max=0; without macro both read 0.

Source files
------------

// File: rtl/tick_period_monitor.sv
// Tick period monitor: measures the interval between rising edges of pulse, tracks lock and missing-tick timeout.
// Optional period_min/period_max tracking is built when TICK_MON_MINMAX_EN is defined.
module tick_period_monitor #(
    parameter int EXPECTED   = 500000,
    parameter int TOL        = 16,
    parameter int LOCK_COUNT = 4,
    parameter int TIMEOUT    = 1000000,
    parameter int CNT_W      = 24
) (
    input  logic             Origin_Clock,
    input  logic             reset,
    input  logic             pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max
);

    typedef enum logic [1:0] {IDLE, MEASURE, LOCKED} state_t;

    localparam int               MC_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W:0]   EXP_C   = (CNT_W+1)'(EXPECTED);
    localparam logic [CNT_W:0]   TOL_C   = (CNT_W+1)'(TOL);
    localparam logic [CNT_W:0]   TMO_C   = (CNT_W+1)'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(TIMEOUT - 1);
    localparam logic [MC_W-1:0]  LOCK_C  = MC_W'(LOCK_COUNT);

    // Absolute deviation taken in one extra bit so neither direction wraps.
    function automatic logic in_tol(input logic [CNT_W:0] p);
        logic [CNT_W:0] d;
        d = (p >= EXP_C) ? (p - EXP_C) : (EXP_C - p);
        return d <= TOL_C;
    endfunction

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [MC_W-1:0]   match_cnt, mc_nx;
    logic [CNT_W:0]    cnt_p1;
    logic [CNT_W-1:0]  period_nx;
    logic              pulse_d, tick, tmo_evt;
    logic              pv_nx, locked_nx, timeout_nx;

    assign tick   = pulse & ~pulse_d;
    assign cnt_p1 = {1'b0, cnt} + 1'b1;

    always_comb begin
        state_nx   = state;
        mc_nx      = match_cnt;
        period_nx  = period;
        pv_nx      = 1'b0;
        locked_nx  = locked;
        timeout_nx = timeout;
        tmo_evt    = 1'b0;
        cnt_nx     = tick ? '0 : ((cnt == CNT_SAT) ? cnt : cnt + 1'b1);
        if (state == IDLE) begin
            if (tick) begin
                state_nx   = MEASURE;
                timeout_nx = 1'b0;
                mc_nx      = '0;
                locked_nx  = 1'b0;
            end
        end else if (tick) begin
            period_nx = cnt_p1[CNT_W-1:0];
            pv_nx     = 1'b1;
            if (in_tol(cnt_p1)) begin
                mc_nx = (match_cnt >= LOCK_C) ? LOCK_C : match_cnt + 1'b1;
                if (mc_nx == LOCK_C) begin
                    state_nx  = LOCKED;
                    locked_nx = 1'b1;
                end
            end else begin
                mc_nx     = '0;
                locked_nx = 1'b0;
                state_nx  = MEASURE;
            end
        end else if (cnt_p1 == TMO_C) begin
            tmo_evt    = 1'b1;
            timeout_nx = 1'b1;
            locked_nx  = 1'b0;
            mc_nx      = '0;
            state_nx   = IDLE;
        end
    end

    always_ff @(posedge Origin_Clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            match_cnt    <= '0;
            pulse_d      <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
        end else begin
            state        <= state_nx;
            cnt          <= cnt_nx;
            match_cnt    <= mc_nx;
            pulse_d      <= pulse;
            period       <= period_nx;
            period_valid <= pv_nx;
            locked       <= locked_nx;
            timeout      <= timeout_nx;
        end
    end

`ifdef TICK_MON_MINMAX_EN
    always_ff @(posedge Origin_Clock or posedge reset) begin
        if (reset) begin
            period_min <= '1;
            period_max <= '0;
        end else if (tmo_evt) begin
            period_min <= '1;
            period_max <= '0;
        end else if (pv_nx) begin
            if (period_nx < period_min) period_min <= period_nx;
            if (period_nx > period_max) period_max <= period_nx;
        end
    end
`else
    assign period_min = '0;
    assign period_max = '0;
`endif

endmodule
